// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Brief    : Writeback result FIFO in front of a register file write port,
//            with hazard lookup. Optional forwarding: WB_QUEUE_FWD_EN.
// Revision : 1.0  initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic [31:0]                in_data,
    input  logic                       rf_hold,
    output logic                       wr_en,
    output logic [4:0]                 w1,
    output logic [31:0]                data,
    input  logic [4:0]                 q_rs,
    output logic                       q_hit,
    output logic [31:0]                q_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [4:0]         r_rd_mem   [DEPTH];
    logic [31:0]        r_data_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_push;
    logic               w_pop;
    logic               w_hit;
    logic [c_PTR_W-1:0] w_hit_idx;

    assign in_ready = (r_count != c_FULL);
    assign count    = r_count;

    // Index-0 results are consumed by the handshake but never enter the FIFO.
    assign w_push = in_valid && in_ready && (in_rd != 5'd0);
    assign w_pop  = (r_count != '0) && !rf_hold;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_tail]   <= in_rd;
            r_data_mem[r_tail] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en <= 1'b0;
            w1    <= 5'd0;
            data  <= 32'd0;
        end else begin
            wr_en <= w_pop;
            if (w_pop) begin
                w1   <= r_rd_mem[r_head];
                data <= r_data_mem[r_head];
            end
        end
    end

    // Only slots between head and head+count hold live entries.
    always_comb begin
        w_hit     = wr_en && (w1 == q_rs);
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit_idx = r_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && (r_rd_mem[w_hit_idx] == q_rs)) begin
                w_hit = 1'b1;
            end
        end
        if (q_rs == 5'd0) begin
            w_hit = 1'b0;
        end
    end

    assign q_hit = w_hit;

`ifdef WB_QUEUE_FWD_EN
    logic [31:0]        w_fwd;
    logic [c_PTR_W-1:0] w_fwd_idx;

    // Scan oldest to newest so the youngest FIFO match overrides the output register.
    always_comb begin
        w_fwd     = (wr_en && (w1 == q_rs)) ? data : 32'd0;
        w_fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + c_PTR_W'(i);
            if ((c_CNT_W'(i) < r_count) && (r_rd_mem[w_fwd_idx] == q_rs)) begin
                w_fwd = r_data_mem[w_fwd_idx];
            end
        end
        if (!w_hit) begin
            w_fwd = 32'd0;
        end
    end

    assign q_data = w_fwd;
`else
    assign q_data = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; SHALL be a power of two in 2..16.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  producer has a writeback result.
REQ-005 Port: in_ready  output  1  queue can accept a result this cycle.
REQ-006 Port: in_rd  input  5  destination register index.
REQ-007 Port: in_data  input  32  result value.
REQ-008 Port: rf_hold  input  1  register file write port unavailable; suppress issue.
REQ-009 Port: wr_en  output  1  register file write enable, registered.
REQ-010 Port: w1  output  5  register file write index, registered.
REQ-011 Port: data  output  32  register file write data, registered.
REQ-012 Port: q_rs  input  5  hazard query index.
REQ-013 Port: q_hit  output  1  write to q_rs pending, combinational.
REQ-014 Port: q_data  output  32  forwarded value for q_rs, combinational.
REQ-015 Port: count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Handshake: transfer occurs on a rising edge when in_valid=1 and in_ready=1; in_ready SHALL be 1 iff count<DEPTH, independent of rf_hold and of same-cycle issue.
REQ-017 Transfer with in_rd=0: accepted, discarded, never stored, never written.
REQ-018 Transfer with in_rd!=0: entry {in_rd,in_data} pushed at FIFO tail.
REQ-019 Issue: each edge with count>0 and rf_hold=0 SHALL pop head into w1/data with wr_en=1; otherwise wr_en=0 on that edge, w1/data hold last value.
REQ-020 Latency: into empty queue, result accepted on edge E SHALL drive wr_en=1 in the cycle after edge E+1 (2 edges); one write per cycle thereafter, FIFO order.
REQ-021 Simultaneous push and pop: count unchanged; legal at count=DEPTH only if in_ready was 1 (i.e. never at full).
REQ-022 Pointers wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-023 rf_hold=1 for any duration: no entries lost, count grows to DEPTH, in_ready drops to 0.
REQ-024 q_hit=1 iff q_rs!=0 and (any valid FIFO entry has rd=q_rs, or wr_en=1 with w1=q_rs); q_rs=0 SHALL give q_hit=0.
REQ-025 q_data SHALL be 0 whenever q_hit=0.

Reset
REQ-026 rst=1 SHALL immediately clear pointers and count, force wr_en=0, w1=0, data=0, in_ready=1 (after release), q_hit=0.
REQ-027 Reset mid-operation: all pending entries discarded; no write issued for them after release.
REQ-028 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro WB_QUEUE_FWD_EN defined: on q_hit=1, q_data SHALL be data of the youngest match (newest FIFO entry over older entries, any FIFO entry over the output register).
REQ-030 WB_QUEUE_FWD_EN undefined: q_data SHALL be constant 0; q_hit unchanged.

Verification
REQ-031 Empty queue, push rd=5 data=0xDEADBEEF, rf_hold=0 -> wr_en=1, w1=5, data=0xDEADBEEF two edges later, single cycle.
REQ-032 Push rd=0 data=0x1234 -> in_ready=1, count stays 0, wr_en never asserted.
REQ-033 rf_hold=1, push 5 entries rd=1..5 (DEPTH=4) -> 4 accepted, in_ready=0 on 5th; release hold -> writes rd=1,2,3,4 on 4 consecutive cycles, then rd=5.
REQ-034 With FWD_EN, rf_hold=1, push rd=7 0x11 then rd=7 0x22, q_rs=7 -> q_hit=1, q_data=0x22; q_rs=0 -> q_hit=0, q_data=0.
REQ-035 Queue holding 3 entries, assert rst mid-cycle -> wr_en=0, count=0 immediately; after release no stale writes occur.
REQ-036 Continuous push every cycle, rf_hold=0, rd cycling 1..31 across pointer wrap -> count never exceeds 1, writes in order, no drops.
